// File: rtl/hq_stream_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hq_stream_pkg
//  Description : Shared constants and FSM encoding for the Hq element stream
//                transmitter (4x2 complex matrix, row-major).
//  Revision    : 1.0 - initial release
// ============================================================================
package hq_stream_pkg;

   localparam int HQ_ROWS  = 4;
   localparam int HQ_COLS  = 2;
   localparam int HQ_ELEMS = HQ_ROWS * HQ_COLS;

   // Shortest idle gap the G-matrix calculator tolerates between frames
   // (4 streaming cycles plus its done cycle).
   localparam int GAP_MIN  = 5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAKE = 2'd1,
      ST_SEND = 2'd2,
      ST_GAP  = 2'd3
   } state_t;

endpackage : hq_stream_pkg
`default_nettype wire

// File: rtl/hq_pingpong_buf.sv
`default_nettype none
// ============================================================================
//  Module      : hq_pingpong_buf
//  Description : Two banks of 8 complex entries with a write port, a
//                combinational read port and per-bank full flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module hq_pingpong_buf
   import hq_stream_pkg::*;
#(
   parameter int N = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                wr_en,
   input  logic                wr_bank,
   input  logic [2:0]          wr_addr,
   input  logic signed [N-1:0] wr_r,
   input  logic signed [N-1:0] wr_i,
   input  logic                rd_bank,
   input  logic [2:0]          rd_addr,
   output logic signed [N-1:0] rd_r,
   output logic signed [N-1:0] rd_i,
   input  logic                set_full,
   input  logic                set_bank,
   input  logic                clr_full,
   input  logic                clr_bank,
   output logic [1:0]          full
);

   logic signed [N-1:0] r_mem_r [2][HQ_ELEMS];
   logic signed [N-1:0] r_mem_i [2][HQ_ELEMS];
   logic [1:0]          r_full;

   // Sample storage; deliberately not reset so no reset fan-out reaches the array
   always_ff @(posedge clk) begin
      if (wr_en) begin
         r_mem_r[wr_bank][wr_addr] <= wr_r;
         r_mem_i[wr_bank][wr_addr] <= wr_i;
      end
   end

   assign rd_r = r_mem_r[rd_bank][rd_addr];
   assign rd_i = r_mem_i[rd_bank][rd_addr];

   // Each flag is updated independently so a release of one bank and a
   // commit of the other on the same edge are both kept.
   for (genvar b = 0; b < 2; b++) begin : g_flag
      logic w_set_hit;
      logic w_clr_hit;
      assign w_set_hit = set_full & (set_bank == 1'(b));
      assign w_clr_hit = clr_full & (clr_bank == 1'(b));

      // Full flag: set wins over clear (cannot coincide on one bank in use)
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_full[b] <= 1'b0;
         end else begin
            r_full[b] <= (r_full[b] & ~w_clr_hit) | w_set_hit;
         end
      end
   end

   assign full = r_full;

endmodule : hq_pingpong_buf
`default_nettype wire

// File: rtl/hq_stream_transmitter.sv
`default_nettype none
// ============================================================================
//  Module      : hq_stream_transmitter
//  Description : Ping-pong buffered producer of the framed Hq element stream
//                (wake beat, 8 data beats, enforced idle gap).
//  Revision    : 1.0 - initial release
// ============================================================================
module hq_stream_transmitter
   import hq_stream_pkg::*;
#(
   parameter int N          = 16,
   parameter int GAP_CYCLES = 5
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                wr_en,
   input  logic [2:0]          wr_addr,
   input  logic signed [N-1:0] wr_r,
   input  logic signed [N-1:0] wr_i,
   input  logic                wr_commit,
   output logic                wr_ready,
   output logic                Hq_out_valid,
   output logic signed [N-1:0] Hq_out_r,
   output logic signed [N-1:0] Hq_out_i,
   output logic                busy,
   output logic                frame_done,
   output logic                err_overflow
);

   localparam int c_GAP_W = $clog2(GAP_CYCLES + 1);

   if (GAP_CYCLES < GAP_MIN) begin : g_gap_check
      $error("GAP_CYCLES is shorter than the calculator recovery time");
   end

   state_t              r_state;
   logic                r_wr_bank;
   logic                r_rd_bank;
   logic [2:0]          r_elem_cnt;
   logic [c_GAP_W-1:0]  r_gap_cnt;
   logic                r_valid;
   logic signed [N-1:0] r_out_r;
   logic signed [N-1:0] r_out_i;
   logic                r_frame_done;
   logic                r_err;

   logic [1:0]          w_full;
   logic                w_wr_ok;
   logic                w_commit_ok;
   logic                w_release;
   logic [2:0]          w_rd_addr;
   logic signed [N-1:0] w_rd_r;
   logic signed [N-1:0] w_rd_i;

   assign wr_ready    = ~w_full[r_wr_bank];
   assign w_wr_ok     = wr_en & wr_ready;
   assign w_commit_ok = wr_commit & wr_ready;
   assign w_release   = (r_state == ST_SEND) && (r_elem_cnt == 3'd7);

   // Look one element ahead so the registered output carries element
   // elem_cnt during the beat labelled elem_cnt.
   assign w_rd_addr = (r_state == ST_SEND) ? (r_elem_cnt + 3'd1) : 3'd0;

   hq_pingpong_buf #(
      .N (N)
   ) u_buf (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (w_wr_ok),
      .wr_bank  (r_wr_bank),
      .wr_addr  (wr_addr),
      .wr_r     (wr_r),
      .wr_i     (wr_i),
      .rd_bank  (r_rd_bank),
      .rd_addr  (w_rd_addr),
      .rd_r     (w_rd_r),
      .rd_i     (w_rd_i),
      .set_full (w_commit_ok),
      .set_bank (r_wr_bank),
      .clr_full (w_release),
      .clr_bank (r_rd_bank),
      .full     (w_full)
   );

   // Fill-bank pointer and overflow pulse for rejected writes/commits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_bank <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         if (w_commit_ok) begin
            r_wr_bank <= ~r_wr_bank;
         end
         r_err <= (wr_en | wr_commit) & ~wr_ready;
      end
   end

   // Frame FSM with registered stream outputs; data holds while valid is low
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_rd_bank    <= 1'b0;
         r_elem_cnt   <= 3'd0;
         r_gap_cnt    <= '0;
         r_valid      <= 1'b0;
         r_out_r      <= '0;
         r_out_i      <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_full[r_rd_bank]) begin
                  r_state <= ST_WAKE;
                  r_valid <= 1'b1;
                  r_out_r <= w_rd_r;
                  r_out_i <= w_rd_i;
               end
            end
            ST_WAKE: begin
               r_state    <= ST_SEND;
               r_elem_cnt <= 3'd0;
               r_valid    <= 1'b1;
               r_out_r    <= w_rd_r;
               r_out_i    <= w_rd_i;
            end
            ST_SEND: begin
               if (r_elem_cnt == 3'd7) begin
                  r_state   <= ST_GAP;
                  r_valid   <= 1'b0;
                  r_rd_bank <= ~r_rd_bank;
                  r_gap_cnt <= c_GAP_W'(GAP_CYCLES - 1);
               end else begin
                  r_elem_cnt   <= r_elem_cnt + 3'd1;
                  r_out_r      <= w_rd_r;
                  r_out_i      <= w_rd_i;
                  r_frame_done <= (r_elem_cnt == 3'd6);
               end
            end
            ST_GAP: begin
               if (r_gap_cnt == '0) begin
                  // Chain straight into the next queued frame to keep the
                  // back-to-back period at wake + 8 beats + gap.
                  if (w_full[r_rd_bank]) begin
                     r_state <= ST_WAKE;
                     r_valid <= 1'b1;
                     r_out_r <= w_rd_r;
                     r_out_i <= w_rd_i;
                  end else begin
                     r_state <= ST_IDLE;
                  end
               end else begin
                  r_gap_cnt <= r_gap_cnt - 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   assign Hq_out_valid = r_valid;
   assign Hq_out_r     = r_out_r;
   assign Hq_out_i     = r_out_i;
   assign frame_done   = r_frame_done;
   assign err_overflow = r_err;
   assign busy         = (r_state != ST_IDLE);

endmodule : hq_stream_transmitter
`default_nettype wire

// File: tb/tb_hq_stream_transmitter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hq_stream_transmitter
//  Description : Directed self-checking bench for hq_stream_transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_hq_stream_transmitter;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               wr_en;
   logic [2:0]         wr_addr;
   logic signed [15:0] wr_r;
   logic signed [15:0] wr_i;
   logic               wr_commit;
   logic               wr_ready;
   logic               Hq_out_valid;
   logic signed [15:0] Hq_out_r;
   logic signed [15:0] Hq_out_i;
   logic               busy;
   logic               frame_done;
   logic               err_overflow;

   hq_stream_transmitter #(.N(16), .GAP_CYCLES(5)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_r         (wr_r),
      .wr_i         (wr_i),
      .wr_commit    (wr_commit),
      .wr_ready     (wr_ready),
      .Hq_out_valid (Hq_out_valid),
      .Hq_out_r     (Hq_out_r),
      .Hq_out_i     (Hq_out_i),
      .busy         (busy),
      .frame_done   (frame_done),
      .err_overflow (err_overflow)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic signed [15:0] mdl_r [6][8];
   logic signed [15:0] mdl_i [6][8];

   int cap_v [64], cap_r [64], cap_i [64], cap_fd [64];
   int cap_rdy [64], cap_err [64], cap_busy [64];
   int exp_v [64], exp_r [64], exp_i [64], exp_fd [64];

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // One input cycle: apply, wait for the edge, then return strobes low
   task automatic drv(input logic we, input logic [2:0] a,
                      input logic signed [15:0] r, input logic signed [15:0] i,
                      input logic cm);
      wr_en = we; wr_addr = a; wr_r = r; wr_i = i; wr_commit = cm;
      @(posedge clk); #1;
      wr_en = 1'b0; wr_commit = 1'b0;
   endtask

   task automatic write_mat(input int id);
      for (int a = 0; a < 8; a++) drv(1'b1, 3'(a), mdl_r[id][a], mdl_i[id][a], 1'b0);
   endtask

   task automatic capture(input int n);
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         cap_v[c]    = int'(Hq_out_valid);
         cap_r[c]    = int'(Hq_out_r);
         cap_i[c]    = int'(Hq_out_i);
         cap_fd[c]   = int'(frame_done);
         cap_rdy[c]  = int'(wr_ready);
         cap_err[c]  = int'(err_overflow);
         cap_busy[c] = int'(busy);
      end
   endtask

   task automatic plan_clear();
      for (int c = 0; c < 64; c++) begin
         exp_v[c] = 0; exp_fd[c] = 0; exp_r[c] = 0; exp_i[c] = 0;
      end
   endtask

   // Wake beat at s carries element 0, data beats s+1..s+8, frame_done at s+8
   task automatic plan_frame(input int s, input int id);
      for (int c = s; c <= s + 8; c++) begin
         int idx;
         idx = (c == s) ? 0 : c - s - 1;
         exp_v[c] = 1;
         exp_r[c] = int'(mdl_r[id][idx]);
         exp_i[c] = int'(mdl_i[id][idx]);
      end
      exp_fd[s + 8] = 1;
   endtask

   task automatic verify(input int n, input string name);
      for (int c = 0; c < n; c++) begin
         chk($sformatf("%s valid@%0d", name, c), cap_v[c], exp_v[c]);
         chk($sformatf("%s frame_done@%0d", name, c), cap_fd[c], exp_fd[c]);
         if (exp_v[c] != 0) begin
            chk($sformatf("%s re@%0d", name, c), cap_r[c], exp_r[c]);
            chk($sformatf("%s im@%0d", name, c), cap_i[c], exp_i[c]);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_r = '0; wr_i = '0; wr_commit = 1'b0;

      for (int a = 0; a < 8; a++) begin
         mdl_r[0][a] = 16'(a + 1);          mdl_i[0][a] = 16'(-(a + 1));
         mdl_r[1][a] = 16'(16'h0100 + a);   mdl_i[1][a] = 16'(16'h0200 + a);
         mdl_r[2][a] = 16'(16'h0300 + a);   mdl_i[2][a] = 16'(16'h0400 + a);
         mdl_r[3][a] = 16'(16'h0500 + a);   mdl_i[3][a] = 16'(-(16'h0500 + a));
         mdl_r[4][a] = 16'(16'h1000 + a);   mdl_i[4][a] = 16'(16'h2000 + a);
         mdl_r[5][a] = mdl_r[3][a];         mdl_i[5][a] = mdl_i[3][a];
      end
      mdl_r[5][7] = 16'sh7FFF;
      mdl_i[5][7] = 16'sh8000;

      // Reset state
      #12;
      chk("rst valid", int'(Hq_out_valid), 0);
      chk("rst wr_ready", int'(wr_ready), 1);
      chk("rst busy", int'(busy), 0);
      chk("rst frame_done", int'(frame_done), 0);
      chk("rst err", int'(err_overflow), 0);
      chk("rst re", int'(Hq_out_r), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      drv(1'b0, 3'd0, 16'sd0, 16'sd0, 1'b0);

      // Single frame into bank 0
      write_mat(0);
      plan_clear();
      plan_frame(2, 0);
      fork
         capture(20);
         drv(1'b0, 3'd0, 16'sd0, 16'sd0, 1'b1);
      join
      verify(20, "single");
      chk("single busy@1", cap_busy[1], 0);
      chk("single busy@2", cap_busy[2], 1);
      chk("single ready@11", cap_rdy[11], 1);

      // Ping-pong: A (bank1), B (bank0) during A, C (bank1) committed on
      // the very edge that releases B's bank
      write_mat(1);
      plan_clear();
      plan_frame(2, 1);
      plan_frame(16, 2);
      plan_frame(30, 3);
      fork
         capture(45);
         begin
            drv(1'b0, 3'd0, 16'sd0, 16'sd0, 1'b1);
            write_mat(2);
            drv(1'b0, 3'd0, 16'sd0, 16'sd0, 1'b1);
            drv(1'b0, 3'd0, 16'sd0, 16'sd0, 1'b0);
            write_mat(3);
            repeat (5) drv(1'b0, 3'd0, 16'sd0, 16'sd0, 1'b0);
            drv(1'b0, 3'd0, 16'sd0, 16'sd0, 1'b1);
         end
      join
      verify(45, "pingpong");
      chk("pingpong ready@9", cap_rdy[9], 1);
      chk("pingpong ready@10", cap_rdy[10], 0);
      chk("pingpong ready@11", cap_rdy[11], 1);

      // Overflow plus same-cycle write+commit of element 7
      write_mat(4);
      plan_clear();
      plan_frame(2, 4);
      plan_frame(16, 5);
      fork
         capture(26);
         begin
            drv(1'b0, 3'd0, 16'sd0, 16'sd0, 1'b1);
            drv(1'b1, 3'd7, 16'sh7FFF, 16'sh8000, 1'b1);
            drv(1'b0, 3'd0, 16'sd0, 16'sd0, 1'b0);
            drv(1'b1, 3'd7, 16'sh7777, 16'sh7777, 1'b0);
            drv(1'b0, 3'd0, 16'sd0, 16'sd0, 1'b0);
            drv(1'b0, 3'd0, 16'sd0, 16'sd0, 1'b1);
         end
      join
      verify(26, "overflow");
      for (int c = 0; c < 26; c++) begin
         chk($sformatf("overflow err@%0d", c), cap_err[c], (c == 4 || c == 6) ? 1 : 0);
      end
      for (int c = 2; c <= 11; c++) begin
         chk($sformatf("overflow ready@%0d", c), cap_rdy[c], (c == 11) ? 1 : 0);
      end

      // Reset mid-SEND at data beat 4, then a fresh frame from retained data
      repeat (6) drv(1'b0, 3'd0, 16'sd0, 16'sd0, 1'b0);
      write_mat(0);
      drv(1'b0, 3'd0, 16'sd0, 16'sd0, 1'b1);
      repeat (5) drv(1'b0, 3'd0, 16'sd0, 16'sd0, 1'b0);
      @(negedge clk);
      chk("midrst pre valid", int'(Hq_out_valid), 1);
      chk("midrst pre re", int'(Hq_out_r), int'(mdl_r[0][3]));
      chk("midrst pre busy", int'(busy), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst valid", int'(Hq_out_valid), 0);
      chk("midrst busy", int'(busy), 0);
      chk("midrst wr_ready", int'(wr_ready), 1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      drv(1'b0, 3'd0, 16'sd0, 16'sd0, 1'b0);
      plan_clear();
      plan_frame(2, 0);
      fork
         capture(14);
         drv(1'b0, 3'd0, 16'sd0, 16'sd0, 1'b1);
      join
      verify(14, "after_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_hq_stream_transmitter
`default_nettype wire
